// File: rtl/mul32u_pkg.sv
// Shared constants and state encoding for the mul32u shift-and-add multiplier.
package mul32u_pkg;

    localparam int unsigned W  = 32;
    localparam int unsigned W2 = 2 * W;
    localparam int unsigned CW = $clog2(W) + 1;

    // Control states, 2-bit encoding.
    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mul32u_mul_step.sv
// One radix-2 accumulate step: adds the shifted multiplicand when the current
// multiplier bit is set.
//   acc        : running partial sum
//   mcand      : multiplicand already shifted for this step
//   mplier_lsb : current multiplier bit
//   acc_nxt    : partial sum after this step
module mul32u_mul_step
    import mul32u_pkg::*;
(
    input  logic [W2-1:0] acc,
    input  logic [W2-1:0] mcand,
    input  logic          mplier_lsb,
    output logic [W2-1:0] acc_nxt
);

    // The full product fits in 2W bits, so this add cannot overflow.
    always_comb begin
        acc_nxt = acc;
        if (mplier_lsb) begin
            acc_nxt = acc + mcand;
        end
    end

endmodule

// File: rtl/mul32u.sv
// Sequential unsigned 32x32->64 multiplier. Operands are captured on the first
// edge after reset release, then one partial product is accumulated per edge
// for W edges; the product then holds until the next reset.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset; arms a new multiply on release
//   op1 : multiplicand
//   op2 : multiplier
//   res : product register (partial sums visible while running)
module mul32u
    import mul32u_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  op1,
    input  logic [W-1:0]  op2,
    output logic [W2-1:0] res
);

    logic [1:0]    state,  state_nxt;
    logic [CW-1:0] cnt,    cnt_nxt;
    logic [W2-1:0] mcand,  mcand_nxt;
    logic [W-1:0]  mplier, mplier_nxt;
    logic [W2-1:0] res_nxt;
    logic [W2-1:0] acc_step;

    mul32u_mul_step u_step (
        .acc        (res),
        .mcand      (mcand),
        .mplier_lsb (mplier[0]),
        .acc_nxt    (acc_step)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_LOAD;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            res    <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            res    <= res_nxt;
        end
    end

    // Next-state and datapath update; DONE simply holds everything.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        res_nxt    = res;
        case (state)
            ST_LOAD: begin
                mcand_nxt  = {W'(0), op1};
                mplier_nxt = op2;
                res_nxt    = '0;
                cnt_nxt    = '0;
                state_nxt  = ST_RUN;
            end
            ST_RUN: begin
                res_nxt    = acc_step;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt + CW'(1);
                if (cnt == CW'(W - 1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_mul32u.sv
// Self-checking bench for mul32u: expected partial sums are queued per run and
// compared one per clock edge.
module tb_mul32u;

    logic        clk;
    logic        rst;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [63:0] res;

    int checks   = 0;
    int failures = 0;
    logic [63:0] sb[$];

    mul32u dut (
        .clk (clk),
        .rst (rst),
        .op1 (op1),
        .op2 (op2),
        .res (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected res after k steps: op1 times the low k bits of op2.
    function automatic logic [63:0] partial(input logic [31:0] a, input logic [31:0] b, input int k);
        logic [32:0] m;
        int kk;
        kk = (k > 32) ? 32 : k;
        m  = (33'd1 << kk) - 33'd1;
        return {32'd0, a} * {32'd0, (b & m[31:0])};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Assert reset between edges, confirm the asynchronous clear, release with new operands.
    task automatic do_reset(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #2;
        rst = 1'b1;
        op1 = a;
        op2 = b;
        #1;
        check("async_reset", res, 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Observe n+1 edges after release (load edge then n steps), comparing each.
    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input int n, input bit scramble);
        logic [63:0] exp;
        for (int k = 0; k <= n; k++) sb.push_back(partial(a, b, k));
        for (int i = 0; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (scramble && i == 0) begin
                op1 = $urandom;
                op2 = $urandom;
            end
            exp = sb.pop_front();
            check(tag, res, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        op1 = '0;
        op2 = '0;
        #12;
        check("reset_state", res, 64'd0);

        do_reset(32'h0000_0002, 32'h8000_0000);
        run("single_top_bit", 32'h0000_0002, 32'h8000_0000, 38, 1'b0);
        check("single_top_bit_final", res, 64'h0000_0001_0000_0000);

        do_reset(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run("max_carry", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 1'b0);
        check("max_carry_final", res, 64'hFFFF_FFFE_0000_0001);

        do_reset(32'h0000_0000, 32'hDEAD_BEEF);
        run("zero_mcand", 32'h0000_0000, 32'hDEAD_BEEF, 34, 1'b0);

        do_reset(32'h1234_5678, 32'h0000_0001);
        run("mplier_one", 32'h1234_5678, 32'h0000_0001, 33, 1'b0);
        check("mplier_one_final", res, 64'h0000_0000_1234_5678);

        do_reset(32'h0000_FFFF, 32'h0001_0001);
        run("scrambled_ops", 32'h0000_FFFF, 32'h0001_0001, 35, 1'b1);
        check("scrambled_final", res, 64'h0000_0000_FFFF_FFFF);

        do_reset(32'd3, 32'd5);
        run("pre_abort", 32'd3, 32'd5, 10, 1'b0);
        do_reset(32'd7, 32'd6);
        run("after_abort", 32'd7, 32'd6, 53, 1'b0);
        check("after_abort_final", res, 64'h0000_0000_0000_002A);

        // Reset while in DONE must clear res before any clock edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("done_async_clear", res, 64'd0);
        #20;
        check("held_in_reset", res, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Overall time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
